// File: rtl/alu_operand_loader.sv
// Operand-entry and result-capture stage for the sign-magnitude ALU.
// Operand A, operand B and the opcode are entered one after another on a
// shared data bus. Each entry is confirmed with a debounced "enter" press.
// The block holds the operand set steady on the ALU inputs and latches the
// ALU result once per operand set.
//
// Handshake: there is no valid/ready pair. op_valid=1 means that a, sa, b,
// sb and seletor are complete and stable (EXEC or SHOW). res_valid=1 means
// that res_* was captured from the current operand set. Both signals are
// level outputs and no acknowledge is expected.
module alu_operand_loader #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 4,
    parameter int NORM_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dado,
    input  logic             sinal,
    input  logic             enter,
    input  logic             clear,
    input  logic [WIDTH:0]   alu_F,
    input  logic             alu_SF,
    input  logic             alu_status,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sa,
    output logic             sb,
    output logic [2:0]       seletor,
    output logic             op_valid,
    output logic [2:0]       estado,
    output logic [WIDTH:0]   res_F,
    output logic             res_SF,
    output logic             res_status,
    output logic             res_valid
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] db_cnt;
    logic          db_level;
    logic          db_level_d;
    logic          press;
    logic          cap_sign;

    // Two-flop synchronizer for the asynchronous button. It resets high, so a
    // button held through reset does not look like a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= enter;
            sync2 <= sync1;
        end
    end

    // Debouncer. The level changes only after DB_CYCLES consecutive differing
    // samples. A rising edge of the level becomes a registered one-cycle press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            db_level   <= 1'b1;
            db_level_d <= 1'b1;
            press      <= 1'b0;
        end else begin
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A zero magnitude can be forced positive so that -0 never reaches the ALU.
    always_comb begin
        cap_sign = sinal;
        if ((NORM_ZERO != 0) && (dado == '0)) begin
            cap_sign = 1'b0;
        end
    end

    // State register. A clear aborts back to LOAD_A and wins over any press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else if (clear) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. EXEC lasts one cycle and ignores any press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (press) state_d = LOAD_B;
            LOAD_B:  if (press) state_d = LOAD_OP;
            LOAD_OP: if (press) state_d = EXEC;
            EXEC:    state_d = SHOW;
            SHOW:    if (press) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    // Operand capture on a press, and result capture at the edge that ends
    // EXEC. Operands keep their old values until they are overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            a          <= '0;
            b          <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            seletor    <= 3'd0;
            res_F      <= '0;
            res_SF     <= 1'b0;
            res_status <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (press) begin
                        a  <= dado;
                        sa <= cap_sign;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b  <= dado;
                        sb <= cap_sign;
                    end
                end
                LOAD_OP: begin
                    if (press) begin
                        seletor <= dado[2:0];
                    end
                end
                EXEC: begin
                    res_F      <= alu_F;
                    res_SF     <= alu_SF;
                    res_status <= alu_status;
                    res_valid  <= 1'b1;
                end
                SHOW: begin
                    if (press) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign estado   = state_q;
    assign op_valid = (state_q == EXEC) || (state_q == SHOW);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader. It uses hand-computed expected
// values and a second instance with NORM_ZERO=0 for the -0 case.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [3:0] dado;
    logic       sinal;
    logic       enter;
    logic       clear;
    logic [4:0] alu_F;
    logic       alu_SF;
    logic       alu_status;

    logic [3:0] a, b;
    logic       sa, sb;
    logic [2:0] seletor;
    logic       op_valid;
    logic [2:0] estado;
    logic [4:0] res_F;
    logic       res_SF, res_status, res_valid;

    logic [3:0] n0_a, n0_b;
    logic       n0_sa, n0_sb;
    logic [2:0] n0_seletor;
    logic       n0_op_valid;
    logic [2:0] n0_estado;
    logic [4:0] n0_res_F;
    logic       n0_res_SF, n0_res_status, n0_res_valid;

    int n_cmp = 0;
    int n_err = 0;

    alu_operand_loader #(.WIDTH(4), .DB_CYCLES(4), .NORM_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .dado(dado), .sinal(sinal), .enter(enter),
        .clear(clear), .alu_F(alu_F), .alu_SF(alu_SF), .alu_status(alu_status),
        .a(a), .b(b), .sa(sa), .sb(sb), .seletor(seletor), .op_valid(op_valid),
        .estado(estado), .res_F(res_F), .res_SF(res_SF), .res_status(res_status),
        .res_valid(res_valid)
    );

    alu_operand_loader #(.WIDTH(4), .DB_CYCLES(4), .NORM_ZERO(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .dado(dado), .sinal(sinal), .enter(enter),
        .clear(clear), .alu_F(alu_F), .alu_SF(alu_SF), .alu_status(alu_status),
        .a(n0_a), .b(n0_b), .sa(n0_sa), .sb(n0_sb), .seletor(n0_seletor),
        .op_valid(n0_op_valid), .estado(n0_estado), .res_F(n0_res_F),
        .res_SF(n0_res_SF), .res_status(n0_res_status), .res_valid(n0_res_valid)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: 10 cycles high, 10 cycles low. The FSM acts on the 8th edge.
    task automatic press(input logic [3:0] d, input logic s);
        dado  = d;
        sinal = s;
        enter = 1'b1;
        idle(10);
        enter = 1'b0;
        idle(10);
    endtask

    initial begin
        rst_n = 1'b0; dado = 4'd0; sinal = 1'b0; enter = 1'b0; clear = 1'b0;
        alu_F = 5'd9; alu_SF = 1'b0; alu_status = 1'b0;
        idle(3);
        check_eq("rst_estado", 32'(estado), 32'd0);
        check_eq("rst_outs", {a, b, sa, sb, seletor, res_F, res_SF, res_status, res_valid, op_valid}, 32'd0);
        rst_n = 1'b1;
        idle(10);   // button low after reset: the release is debounced, with no press

        // Test 1: 3 + (-5), add. The bench ALU result is F=2, SF=1.
        check_eq("idle_estado", 32'(estado), 32'd0);
        press(4'd3, 1'b0);
        check_eq("t1_a", 32'(a), 32'd3);
        check_eq("t1_sa", 32'(sa), 32'd0);
        check_eq("t1_estado_b", 32'(estado), 32'd1);
        press(4'd5, 1'b1);
        check_eq("t1_b", 32'(b), 32'd5);
        check_eq("t1_sb", 32'(sb), 32'd1);
        check_eq("t1_estado_op", 32'(estado), 32'd2);
        check_eq("t1_opv_lo", 32'(op_valid), 32'd0);
        dado = 4'd0; sinal = 1'b0; enter = 1'b1;
        idle(8);
        check_eq("t1_estado_exec", 32'(estado), 32'd3);
        check_eq("t1_opv_hi", 32'(op_valid), 32'd1);
        check_eq("t1_sel", 32'(seletor), 32'd0);
        check_eq("t1_resv_exec", 32'(res_valid), 32'd0);
        alu_F = 5'd2; alu_SF = 1'b1;
        idle(1);
        alu_F = 5'h1b; alu_SF = 1'b0;
        check_eq("t1_estado_show", 32'(estado), 32'd4);
        check_eq("t1_res_F", 32'(res_F), 32'd2);
        check_eq("t1_res_SF", 32'(res_SF), 32'd1);
        check_eq("t1_res_valid", 32'(res_valid), 32'd1);
        idle(1);
        enter = 1'b0;
        idle(10);
        check_eq("t1_res_hold", 32'(res_F), 32'd2);
        check_eq("t1_show_hold", 32'(estado), 32'd4);

        // Press in SHOW returns to LOAD_A. The operands are kept.
        press(4'd1, 1'b0);
        check_eq("show_ret_estado", 32'(estado), 32'd0);
        check_eq("show_ret_resv", 32'(res_valid), 32'd0);
        check_eq("show_ret_a", 32'(a), 32'd3);

        // Test 2: a 3-cycle glitch gives no press. Then measure the latency.
        dado = 4'd9; enter = 1'b1;
        idle(3);
        enter = 1'b0;
        idle(12);
        check_eq("t2_glitch_estado", 32'(estado), 32'd0);
        check_eq("t2_glitch_a", 32'(a), 32'd3);
        dado = 4'd6; sinal = 1'b0; enter = 1'b1;
        idle(7);
        check_eq("t2_lat_7", 32'(estado), 32'd0);
        idle(1);
        check_eq("t2_lat_8", 32'(estado), 32'd1);
        check_eq("t2_a", 32'(a), 32'd6);
        idle(2);
        enter = 1'b0;
        idle(10);

        // Test 4: clear in the same cycle as a press in LOAD_B.
        dado = 4'd7; sinal = 1'b1; enter = 1'b1;
        idle(7);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_eq("t4_estado", 32'(estado), 32'd0);
        check_eq("t4_b", 32'(b), 32'd0);
        check_eq("t4_sb", 32'(sb), 32'd0);
        check_eq("t4_a", 32'(a), 32'd0);
        idle(2);
        enter = 1'b0;
        idle(10);
        check_eq("t4_no_late", 32'(estado), 32'd0);

        // Test 3: a zero magnitude with the sign set.
        press(4'd0, 1'b1);
        check_eq("t3_a", 32'(a), 32'd0);
        check_eq("t3_sa_norm", 32'(sa), 32'd0);
        check_eq("t3_sa_raw", 32'(n0_sa), 32'd1);
        check_eq("t3_estado", 32'(estado), 32'd1);

        // Test 6: opcode 4 (the dado[3] bit is ignored). The compare flag is latched.
        press(4'd2, 1'b0);
        dado = 4'd12; sinal = 1'b0; enter = 1'b1;
        idle(8);
        check_eq("t6_estado_exec", 32'(estado), 32'd3);
        check_eq("t6_sel", 32'(seletor), 32'd4);
        alu_status = 1'b1;
        idle(1);
        alu_status = 1'b0;
        check_eq("t6_status", 32'(res_status), 32'd1);
        idle(12);   // button still held: a single press, so SHOW holds
        check_eq("t6_held_estado", 32'(estado), 32'd4);
        check_eq("t6_status_hold", 32'(res_status), 32'd1);
        enter = 1'b0;
        idle(10);
        press(4'd0, 1'b0);
        check_eq("t6_ret_estado", 32'(estado), 32'd0);
        check_eq("t6_ret_resv", 32'(res_valid), 32'd0);

        // Test 5: reset in SHOW with the button held through and after reset.
        alu_F = 5'd3; alu_SF = 1'b1;
        press(4'd1, 1'b1);
        press(4'd2, 1'b0);
        press(4'd1, 1'b0);
        check_eq("t5_pre_resv", 32'(res_valid), 32'd1);
        check_eq("t5_pre_estado", 32'(estado), 32'd4);
        enter = 1'b1; rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check_eq("t5_estado", 32'(estado), 32'd0);
        check_eq("t5_outs", {a, b, sa, sb, seletor, res_F, res_SF, res_status, res_valid, op_valid}, 32'd0);
        idle(20);
        check_eq("t5_held_no_press", 32'(estado), 32'd0);
        enter = 1'b0;
        idle(10);
        press(4'd4, 1'b0);
        check_eq("t5_repress", 32'(estado), 32'd1);
        check_eq("t5_a", 32'(a), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
